// File: rtl/func_gen_pkg.sv
// Shared encodings for the DDS function generator: waveform selects and
// amplitude shift codes.
package func_gen_pkg;

    typedef enum logic [2:0] {
        WAVE_SQUARE   = 3'd0,
        WAVE_SAW_UP   = 3'd1,
        WAVE_SAW_DOWN = 3'd2,
        WAVE_TRIANGLE = 3'd3,
        WAVE_DC       = 3'd4
    } wave_sel_e;

    localparam logic [1:0] AMP_FULL    = 2'd0;
    localparam logic [1:0] AMP_HALF    = 2'd1;
    localparam logic [1:0] AMP_QUARTER = 2'd2;
    localparam logic [1:0] AMP_EIGHTH  = 2'd3;

endpackage

// File: rtl/pwm_dac.sv
// PWM DAC: free-running period counter, duty latched only at the period
// boundary so a level change never truncates or stretches the current pulse.
module pwm_dac #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] level,
    output logic         out,
    output logic [W-1:0] sample
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] duty_q, duty_d;
    logic         out_q, out_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        duty_d = (cnt_q == '1) ? level : duty_q;
        out_d  = (cnt_q < duty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            duty_q <= '0;
            out_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            out_q  <= out_d;
        end
    end

    assign out    = out_q;
    assign sample = duty_q;

endmodule

// File: rtl/func_gen_dds.sv
// DDS function generator: divider-paced phase counter, waveform shaper,
// amplitude shifter and boundary-latched PWM DAC output.
module func_gen_dds
    import func_gen_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned DIVW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            ld,
    input  logic [DIVW-1:0] cnt_load,
    input  logic            phase_clr,
    input  logic [2:0]      wave_sel,
    input  logic [W-1:0]    duty,
    input  logic [1:0]      amp_sel,
    output logic            out,
    output logic [W-1:0]    sample,
    output logic            tick,
    output logic            wrap
);

    logic [DIVW-1:0] reload_q, reload_d;
    logic [DIVW-1:0] div_cnt_q, div_cnt_d;
    logic            tick_q, tick_d;
    logic [W-1:0]    phase_q, phase_d;
    logic            wrap_q, wrap_d;
    logic [W-1:0]    wave_q, wave_d;
    logic [W-1:0]    shaped;
    logic [W-1:0]    tri_base;

    // Divider: ld overrides en, so a pending tick is dropped on a load cycle.
    always_comb begin
        reload_d  = reload_q;
        div_cnt_d = div_cnt_q;
        tick_d    = 1'b0;
        if (ld) begin
            reload_d  = cnt_load;
            div_cnt_d = cnt_load;
        end else if (en) begin
            if (div_cnt_q == '1) begin
                div_cnt_d = reload_q;
                tick_d    = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        wrap_d  = 1'b0;
        if (phase_clr) begin
            phase_d = '0;
        end else if (tick_q) begin
            phase_d = phase_q + 1'b1;
            wrap_d  = (phase_q == '1);
        end
    end

    always_comb begin
        tri_base = {phase_q[W-2:0], 1'b0};
        shaped   = '0;
        case (wave_sel_e'(wave_sel))
            WAVE_SQUARE:   shaped = (phase_q < duty) ? '1 : '0;
            WAVE_SAW_UP:   shaped = phase_q;
            WAVE_SAW_DOWN: shaped = ~phase_q;
            WAVE_TRIANGLE: shaped = phase_q[W-1] ? ~tri_base : tri_base;
            WAVE_DC:       shaped = {1'b1, {(W-1){1'b0}}};
            default:       shaped = '0;
        endcase
    end

    always_comb begin
        wave_d = shaped;
        case (amp_sel)
            AMP_FULL:    wave_d = shaped;
            AMP_HALF:    wave_d = shaped >> 1;
            AMP_QUARTER: wave_d = shaped >> 2;
            AMP_EIGHTH:  wave_d = shaped >> 3;
            default:     wave_d = shaped;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_q  <= '0;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            phase_q   <= '0;
            wrap_q    <= 1'b0;
            wave_q    <= '0;
        end else begin
            reload_q  <= reload_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
            wrap_q    <= wrap_d;
            wave_q    <= wave_d;
        end
    end

    pwm_dac #(.W(W)) u_pwm (
        .clk    (clk),
        .rst_n  (rst),
        .level  (wave_q),
        .out    (out),
        .sample (sample)
    );

    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_func_gen_dds.sv
// Self-checking bench for func_gen_dds (W=8, DIVW=5): expected values are
// queued when stimulus is applied and compared when the output is observed.
module tb_func_gen_dds;

    localparam int W    = 8;
    localparam int DIVW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            ld;
    logic [DIVW-1:0] cnt_load;
    logic            phase_clr;
    logic [2:0]      wave_sel;
    logic [W-1:0]    duty;
    logic [1:0]      amp_sel;
    logic            out;
    logic [W-1:0]    sample;
    logic            tick;
    logic            wrap;

    int n_chk  = 0;
    int n_pass = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    func_gen_dds #(.W(W), .DIVW(DIVW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ld        (ld),
        .cnt_load  (cnt_load),
        .phase_clr (phase_clr),
        .wave_sel  (wave_sel),
        .duty      (duty),
        .amp_sel   (amp_sel),
        .out       (out),
        .sample    (sample),
        .tick      (tick),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic score(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            n += int'(out);
        end
    endtask

    // Steps phase to target using one tick per clock (reload must be all-ones).
    task automatic set_phase(input int target);
        if (target == 0) begin
            @(negedge clk) phase_clr = 1'b1;
            @(negedge clk) phase_clr = 1'b0;
        end else begin
            bit hit = 1'b0;
            @(negedge clk) en = 1'b1;
            for (int i = 0; i < 600 && !hit; i++) begin
                @(negedge clk);
                if (int'(dut.phase_q) == target - 1) begin
                    en  = 1'b0;
                    hit = 1'b1;
                end
            end
            en = 1'b0;
            check("set_phase_timeout", 32'(hit), 32'd1);
        end
        repeat (2) @(negedge clk);
        check("phase_reached", 32'(dut.phase_q), 32'(target));
    endtask

    task automatic measure(input string name, input int exp_sample, input int exp_high);
        int hi;
        expect_val({name, "_sample"}, 32'(exp_sample));
        expect_val({name, "_high"}, 32'(exp_high));
        repeat (2 * 256 + 4) @(negedge clk);
        score(32'(sample));
        count_high(hi);
        score(32'(hi));
    endtask

    task automatic tick_interval(input string name, input int exp_gap);
        int gap;
        bit seen;
        expect_val(name, 32'(exp_gap));
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = tick;
        end
        gap = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            gap++;
            seen = tick;
        end
        score(seen ? 32'(gap) : 32'hFFFF_FFFF);
    endtask

    initial begin
        int n, gap, toggles, ticks;
        bit prev, done;

        rst = 1'b0; en = 1'b0; ld = 1'b0; cnt_load = '0; phase_clr = 1'b0;
        wave_sel = 3'd0; duty = '0; amp_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        rst = 1'b1;

        // Divider pacing
        @(negedge clk) begin ld = 1'b1; cnt_load = 5'd28; end
        @(negedge clk) begin ld = 1'b0; en = 1'b1; end
        tick_interval("tick_gap_28", 4);
        @(negedge clk) begin ld = 1'b1; cnt_load = 5'd31; end
        @(negedge clk) ld = 1'b0;
        tick_interval("tick_gap_31", 1);

        // ld while a tick would be produced suppresses it
        @(negedge clk) ld = 1'b1;
        @(negedge clk) begin
            ld = 1'b0;
            check("ld_suppresses_tick", 32'(tick), 32'd0);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Saw up at phase 64, full then quarter amplitude
        set_phase(0);
        set_phase(64);
        wave_sel = 3'd1; amp_sel = 2'd0;
        measure("saw_up_a0", 64, 64);
        amp_sel = 2'd2;
        measure("saw_up_a2", 16, 16);

        // Triangle and the other shapes
        wave_sel = 3'd3; amp_sel = 2'd0;
        measure("tri_40", 8'h80, 8'h80);
        set_phase(8'hC0);
        measure("tri_C0", 8'h7F, 8'h7F);
        wave_sel = 3'd0; duty = 8'h80;
        measure("sq_C0", 0, 0);
        set_phase(0);
        measure("sq_00", 8'hFF, 8'hFF);
        duty = 8'h00;
        measure("sq_duty0", 0, 0);
        wave_sel = 3'd2;
        measure("saw_dn_00", 8'hFF, 8'hFF);
        wave_sel = 3'd4; amp_sel = 2'd3;
        measure("dc_a3", 8'h10, 8'h10);
        wave_sel = 3'd6;
        measure("sel6_zero", 0, 0);

        // Glitch-free: change shape in the middle of a pulse
        set_phase(64);
        wave_sel = 3'd1; amp_sel = 2'd0;
        repeat (2 * 256 + 4) @(negedge clk);
        expect_val("glitch_cur_width", 32'd64);
        expect_val("glitch_cur_sample", 32'd64);
        expect_val("glitch_next_width", 32'd128);
        prev = out; done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            done = out && !prev;
            prev = out;
        end
        n = 1;
        repeat (10) begin
            @(negedge clk);
            n += int'(out);
        end
        wave_sel = 3'd4;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (out) n++;
            else done = 1'b1;
        end
        score(32'(n));
        score(32'(sample));
        prev = out; done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            done = out && !prev;
            prev = out;
        end
        n = 1; done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (out) n++;
            else done = 1'b1;
        end
        score(32'(n));

        // Wrap period with a tick every clock
        expect_val("wrap_gap", 32'd256);
        @(negedge clk) en = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            done = wrap;
        end
        gap = 0; done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            gap++;
            done = wrap;
        end
        score(done ? 32'(gap) : 32'hFFFF_FFFF);

        // phase_clr coincident with a tick at phase 0xFF
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (dut.phase_q == 8'hFF && tick) begin
                phase_clr = 1'b1;
                en = 1'b0;
                done = 1'b1;
            end
        end
        check("clr_align_timeout", 32'(done), 32'd1);
        @(negedge clk) begin
            phase_clr = 1'b0;
            check("clr_phase", 32'(dut.phase_q), 32'd0);
            check("clr_no_wrap", 32'(wrap), 32'd0);
        end
        @(negedge clk) check("clr_no_wrap_next", 32'(wrap), 32'd0);

        // en=0: no ticks, phase frozen, PWM still running (DC mid -> 2 edges/period)
        wave_sel = 3'd4; amp_sel = 2'd0;
        repeat (2 * 256 + 4) @(negedge clk);
        toggles = 0; ticks = 0; prev = out;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (out != prev) toggles++;
            ticks += int'(tick);
            prev = out;
        end
        check("en0_ticks", 32'(ticks), 32'd0);
        check("en0_phase", 32'(dut.phase_q), 32'd0);
        check("en0_toggles", 32'(toggles), 32'd4);

        // Asynchronous reset mid-run
        @(negedge clk) en = 1'b1;
        repeat (37) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_out", 32'(out), 32'd0);
        check("arst_sample", 32'(sample), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_wrap", 32'(wrap), 32'd0);
        check("arst_phase", 32'(dut.phase_q), 32'd0);
        @(negedge clk) rst = 1'b1;
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_out", 32'(out), 32'd0);

        if (exp_q.size() != 0) check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
